// File: rtl/membus_master_pkg.sv
// Shared definitions for the membus initiator: state encoding, bus field
// types, default timeouts and the timer width.
package membus_master_pkg;

    localparam int ACK_TIMEOUT_DEF = 1000;
    localparam int RS_TIMEOUT_DEF  = 2000;
    localparam int DATA_SETUP_DEF  = 4;
    localparam int TMR_W           = 12;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RD,
        WAIT_MOD,
        DRIVE,
        WRRS,
        RELEASE,
        ABORT
    } state_t;

    typedef logic [21:35] ma_t;
    typedef logic [18:21] sel_t;
    typedef logic [0:35]  word_t;

    // All bus levels owned by the master, so a single '0 releases the bus.
    typedef struct packed {
        logic  rq_cyc;
        logic  rd_rq;
        logic  wr_rq;
        ma_t   ma;
        sel_t  sel;
        logic  fmc;
        word_t mb_out;
    } bus_t;

    // A down-counter loaded with cycles-1 expires on the cycles-th cycle.
    function automatic logic [TMR_W-1:0] tmr_count(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/membus_master_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module membus_timer
    import membus_master_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/membus_master.sv
// Processor-side membus initiator: read, write and read-modify-write cycles
// with a nonexistent-memory / missing-restart timeout.
module membus_master
    import membus_master_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int RS_TIMEOUT  = RS_TIMEOUT_DEF,
    parameter int DATA_SETUP  = DATA_SETUP_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_start,
    input  logic         req_rd,
    input  logic         req_wr,
    input  logic [21:35] req_ma,
    input  logic [18:21] req_sel,
    input  logic         req_fmc,
    input  logic [0:35]  req_wdata,
    input  logic         mod_go,
    output logic         busy,
    output logic         rd_done,
    output logic [0:35]  rdata,
    output logic         done,
    output logic         err,
    output logic         membus_rq_cyc,
    output logic         membus_rd_rq,
    output logic         membus_wr_rq,
    output logic [21:35] membus_ma,
    output logic [18:21] membus_sel,
    output logic         membus_fmc_select,
    output logic [0:35]  membus_mb_out,
    output logic         membus_wr_rs,
    input  logic         membus_addr_ack,
    input  logic         membus_rd_rs,
    input  logic [0:35]  membus_mb_in
);

    state_t            state;
    bus_t              bus;
    logic              cyc_rd;
    logic              cyc_wr;
    word_t             cyc_wdata;
    logic              ack_q;
    logic              rs_q;
    logic              rs_pend;
    logic              ack_rise;
    logic              rs_hit;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    assign ack_rise = membus_addr_ack & ~ack_q;
    // An rd_rs edge that arrived together with the ack is honoured in WAIT_RD.
    assign rs_hit   = (membus_rd_rs & ~rs_q) | rs_pend;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                tmr_load = 1'b1;
                tmr_val  = tmr_count(ACK_TIMEOUT);
            end
            WAIT_ACK: begin
                if (ack_rise) begin
                    tmr_load = 1'b1;
                    tmr_val  = cyc_rd ? tmr_count(RS_TIMEOUT) : tmr_count(DATA_SETUP);
                end
            end
            WAIT_MOD: begin
                tmr_load = 1'b1;
                tmr_val  = tmr_count(DATA_SETUP);
            end
            default: ;
        endcase
    end

    membus_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus          <= '0;
            busy         <= 1'b0;
            rd_done      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            membus_wr_rs <= 1'b0;
            rdata        <= '0;
            cyc_rd       <= 1'b0;
            cyc_wr       <= 1'b0;
            cyc_wdata    <= '0;
            ack_q        <= 1'b0;
            rs_q         <= 1'b0;
            rs_pend      <= 1'b0;
        end else begin
            ack_q        <= membus_addr_ack;
            rs_q         <= membus_rd_rs;
            rs_pend      <= (state == WAIT_ACK) & ack_rise & membus_rd_rs & ~rs_q;
            rd_done      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            membus_wr_rs <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (req_start) begin
                        busy      <= 1'b1;
                        rdata     <= '0;
                        cyc_rd    <= req_rd;
                        cyc_wr    <= req_wr;
                        cyc_wdata <= req_wdata;
                        if (req_rd | req_wr) begin
                            state      <= WAIT_ACK;
                            bus.rq_cyc <= 1'b1;
                            bus.rd_rq  <= req_rd;
                            bus.wr_rq  <= req_wr;
                            bus.ma     <= req_ma;
                            bus.sel    <= req_sel;
                            bus.fmc    <= req_fmc;
                        end else begin
                            state <= RELEASE;
                            done  <= 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (ack_rise) begin
                        if (cyc_rd) begin
                            state <= WAIT_RD;
                        end else begin
                            state      <= DRIVE;
                            bus.mb_out <= cyc_wdata;
                        end
                    end else if (tmr_expired) begin
                        state <= ABORT;
                        err   <= 1'b1;
                        bus   <= '0;
                    end
                end
                WAIT_RD: begin
                    rdata <= rdata | membus_mb_in;
                    if (rs_hit) begin
                        rd_done <= 1'b1;
                        if (cyc_wr) begin
                            state <= WAIT_MOD;
                        end else begin
                            state <= RELEASE;
                            done  <= 1'b1;
                            bus   <= '0;
                        end
                    end else if (tmr_expired) begin
                        state <= ABORT;
                        err   <= 1'b1;
                        bus   <= '0;
                    end
                end
                WAIT_MOD: begin
                    if (mod_go) begin
                        state      <= DRIVE;
                        bus.mb_out <= req_wdata;
                    end
                end
                DRIVE: begin
                    if (tmr_expired) begin
                        state        <= WRRS;
                        membus_wr_rs <= 1'b1;
                    end
                end
                WRRS: begin
                    state <= RELEASE;
                    done  <= 1'b1;
                    bus   <= '0;
                end
                RELEASE, ABORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign membus_rq_cyc     = bus.rq_cyc;
    assign membus_rd_rq      = bus.rd_rq;
    assign membus_wr_rq      = bus.wr_rq;
    assign membus_ma         = bus.ma;
    assign membus_sel        = bus.sel;
    assign membus_fmc_select = bus.fmc;
    assign membus_mb_out     = bus.mb_out;

endmodule

// File: tb/tb_membus_master.sv
// Directed bench for membus_master with a small core-memory responder model.
module tb_membus_master;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_start, req_rd, req_wr, req_fmc, mod_go;
    logic [21:35] req_ma;
    logic [18:21] req_sel;
    logic [0:35]  req_wdata;
    logic         busy, rd_done, done, err;
    logic [0:35]  rdata;
    logic         membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_fmc_select, membus_wr_rs;
    logic [21:35] membus_ma;
    logic [18:21] membus_sel;
    logic [0:35]  membus_mb_out;
    logic         membus_addr_ack, membus_rd_rs;
    logic [0:35]  membus_mb_in;
    logic         mem_en;

    logic [0:35]  mem [0:32767];

    int n_done, n_err, n_rdd, n_wrrs, mb_run, setup_len, low_run, last_gap;
    logic [0:35] rd_word, wr_word;

    int ntests = 0;
    int nfail  = 0;
    int b_done, b_err, b_rdd, b_wrrs;

    membus_master dut (
        .clk(clk), .reset(reset), .req_start(req_start), .req_rd(req_rd), .req_wr(req_wr),
        .req_ma(req_ma), .req_sel(req_sel), .req_fmc(req_fmc), .req_wdata(req_wdata),
        .mod_go(mod_go), .busy(busy), .rd_done(rd_done), .rdata(rdata), .done(done), .err(err),
        .membus_rq_cyc(membus_rq_cyc), .membus_rd_rq(membus_rd_rq), .membus_wr_rq(membus_wr_rq),
        .membus_ma(membus_ma), .membus_sel(membus_sel), .membus_fmc_select(membus_fmc_select),
        .membus_mb_out(membus_mb_out), .membus_wr_rs(membus_wr_rs),
        .membus_addr_ack(membus_addr_ack), .membus_rd_rs(membus_rd_rs), .membus_mb_in(membus_mb_in)
    );

    always #5 clk = ~clk;

    // Core memory responder: ack two cycles after rq_cyc, read restart two cycles later.
    initial begin
        int cs;
        int cnt;
        cs = 0;
        cnt = 0;
        membus_addr_ack = 1'b0;
        membus_rd_rs = 1'b0;
        membus_mb_in = '0;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        mem[15'o01234] = 36'o123456701234;
        mem[15'o00005] = 36'o000000000001;
        forever begin
            @(negedge clk);
            membus_rd_rs = 1'b0;
            membus_mb_in = '0;
            if (membus_rq_cyc !== 1'b1) begin
                membus_addr_ack = 1'b0;
                cs = 0;
                cnt = 0;
            end else begin
                case (cs)
                    0: if (mem_en) begin
                        cnt++;
                        if (cnt == 2) begin
                            membus_addr_ack = 1'b1;
                            cnt = 0;
                            cs = membus_rd_rq ? 1 : 2;
                        end
                    end
                    1: begin
                        cnt++;
                        if (cnt == 2) begin
                            membus_rd_rs = 1'b1;
                            membus_mb_in = mem[membus_ma];
                            cs = 2;
                        end
                    end
                    2: if (membus_wr_rq && membus_wr_rs) begin
                        mem[membus_ma] = membus_mb_out;
                        cs = 3;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output monitor, sampled 1 time unit after each rising edge.
    initial begin
        n_done = 0; n_err = 0; n_rdd = 0; n_wrrs = 0;
        mb_run = 0; setup_len = 0; low_run = 0; last_gap = 0;
        rd_word = '0; wr_word = '0;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
            if (err === 1'b1) n_err++;
            if (rd_done === 1'b1) begin
                n_rdd++;
                rd_word = rdata;
            end
            if (membus_wr_rs === 1'b1) begin
                n_wrrs++;
                setup_len = mb_run;
                wr_word = membus_mb_out;
            end
            if (membus_mb_out === '0) mb_run = 0;
            else if (membus_wr_rs !== 1'b1) mb_run++;
            if (membus_rq_cyc !== 1'b1) low_run++;
            else begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0o expected %0o", name, obs, exp);
        end
    endtask

    task automatic snap();
        b_done = n_done;
        b_err  = n_err;
        b_rdd  = n_rdd;
        b_wrrs = n_wrrs;
    endtask

    task automatic start_req(input logic rd, input logic wr, input logic [21:35] ma,
                             input logic [18:21] sel, input logic [0:35] wd);
        @(negedge clk);
        req_rd = rd; req_wr = wr; req_ma = ma; req_sel = sel; req_wdata = wd;
        req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output int cycles);
        cycles = 0;
        while (n_done == b_done && n_err == b_err && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("end_within_budget", 64'(cycles < budget), 64'(1));
    endtask

    task automatic wait_rdd(input int budget);
        int cycles;
        cycles = 0;
        while (n_rdd == b_rdd && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("rd_done_within_budget", 64'(cycles < budget), 64'(1));
    endtask

    initial begin
        int cyc;
        logic [0:35] w1;
        reset = 1'b1;
        req_start = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_fmc = 1'b0; mod_go = 1'b0;
        req_ma = '0; req_sel = '0; req_wdata = '0;
        mem_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_rq_cyc", 64'(membus_rq_cyc), 64'(0));
        check("rst_rdata",  64'(rdata), 64'(0));
        check("rst_done",   64'(done), 64'(0));
        check("rst_mb_out", 64'(membus_mb_out), 64'(0));
        check("rst_wr_rs",  64'(membus_wr_rs), 64'(0));
        reset = 1'b0;

        // Read
        snap();
        start_req(1'b1, 1'b0, 15'o01234, 4'd0, 36'o0);
        check("rd_busy", 64'(busy), 64'(1));
        check("rd_rq_cyc", 64'(membus_rq_cyc), 64'(1));
        check("rd_rd_rq", 64'(membus_rd_rq), 64'(1));
        check("rd_ma", 64'(membus_ma), 64'(15'o01234));
        wait_end(100, cyc);
        check("rd_done_cnt", 64'(n_done - b_done), 64'(1));
        check("rd_err_cnt", 64'(n_err - b_err), 64'(0));
        check("rd_rddone_cnt", 64'(n_rdd - b_rdd), 64'(1));
        check("rd_word", 64'(rd_word), 64'(36'o123456701234));
        check("rd_no_wrrs", 64'(n_wrrs - b_wrrs), 64'(0));
        @(negedge clk);
        check("rd_rq_cyc_after", 64'(membus_rq_cyc), 64'(0));
        check("rd_busy_after", 64'(busy), 64'(0));
        check("rd_rdata_held", 64'(rdata), 64'(36'o123456701234));

        // Write
        snap();
        start_req(1'b0, 1'b1, 15'o00100, 4'd3, 36'o777000000777);
        check("wr_sel", 64'(membus_sel), 64'(3));
        check("wr_wr_rq", 64'(membus_wr_rq), 64'(1));
        wait_end(100, cyc);
        check("wr_wrrs_cnt", 64'(n_wrrs - b_wrrs), 64'(1));
        check("wr_setup_len", 64'(setup_len), 64'(4));
        check("wr_bus_word", 64'(wr_word), 64'(36'o777000000777));
        check("wr_mem_word", 64'(mem[15'o00100]), 64'(36'o777000000777));
        check("wr_done_cnt", 64'(n_done - b_done), 64'(1));
        @(negedge clk);
        check("wr_mb_out_released", 64'(membus_mb_out), 64'(0));

        // Read-modify-write
        snap();
        start_req(1'b1, 1'b1, 15'o00005, 4'd0, 36'o55);
        wait_rdd(100);
        check("rmw_rd_word", 64'(rd_word), 64'(1));
        repeat (6) @(negedge clk);
        check("rmw_hold_rq_cyc", 64'(membus_rq_cyc), 64'(1));
        check("rmw_no_early_drive", 64'(membus_mb_out), 64'(0));
        check("rmw_no_early_done", 64'(n_done - b_done), 64'(0));
        @(negedge clk);
        req_wdata = 36'o2;
        mod_go = 1'b1;
        @(negedge clk);
        mod_go = 1'b0;
        req_wdata = 36'o0;
        wait_end(100, cyc);
        check("rmw_wrrs_cnt", 64'(n_wrrs - b_wrrs), 64'(1));
        check("rmw_bus_word", 64'(wr_word), 64'(2));
        check("rmw_mem_word", 64'(mem[15'o00005]), 64'(2));
        check("rmw_rdata", 64'(rdata), 64'(1));
        check("rmw_done_cnt", 64'(n_done - b_done), 64'(1));

        // Null request
        snap();
        start_req(1'b0, 1'b0, 15'o01234, 4'd0, 36'o0);
        wait_end(10, cyc);
        check("null_done_cnt", 64'(n_done - b_done), 64'(1));
        check("null_latency", 64'(cyc), 64'(0));
        check("null_rq_cyc", 64'(membus_rq_cyc), 64'(0));

        // Nonexistent memory timeout
        mem_en = 1'b0;
        snap();
        start_req(1'b1, 1'b0, 15'o07777, 4'd0, 36'o0);
        wait_end(1100, cyc);
        check("to_err_cnt", 64'(n_err - b_err), 64'(1));
        check("to_done_cnt", 64'(n_done - b_done), 64'(0));
        check("to_cycles", 64'(cyc), 64'(1000));
        check("to_rq_cyc", 64'(membus_rq_cyc), 64'(0));
        check("to_rd_rq", 64'(membus_rd_rq), 64'(0));
        check("to_ma", 64'(membus_ma), 64'(0));
        @(negedge clk);
        check("to_busy_after", 64'(busy), 64'(0));
        mem_en = 1'b1;

        // Reset while waiting for mod_go
        snap();
        start_req(1'b1, 1'b1, 15'o00005, 4'd0, 36'o0);
        wait_rdd(100);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_rq_cyc", 64'(membus_rq_cyc), 64'(0));
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_rdata", 64'(rdata), 64'(0));
        repeat (3) @(negedge clk);
        check("mrst_no_done", 64'(n_done - b_done), 64'(0));
        check("mrst_no_err", 64'(n_err - b_err), 64'(0));
        check("mrst_mem_kept", 64'(mem[15'o00005]), 64'(2));
        snap();
        start_req(1'b1, 1'b0, 15'o01234, 4'd0, 36'o0);
        wait_end(100, cyc);
        check("mrst_read_done", 64'(n_done - b_done), 64'(1));
        check("mrst_read_word", 64'(rd_word), 64'(36'o123456701234));

        // Back-to-back reads with start held across done
        snap();
        @(negedge clk);
        req_rd = 1'b1; req_wr = 1'b0; req_ma = 15'o01234; req_sel = 4'd0;
        req_start = 1'b1;
        wait_end(100, cyc);
        w1 = rd_word;
        req_ma = 15'o00100;
        @(negedge clk);
        @(negedge clk);
        req_start = 1'b0;
        check("b2b_second_busy", 64'(busy), 64'(1));
        b_done = n_done;
        wait_end(100, cyc);
        check("b2b_word1", 64'(w1), 64'(36'o123456701234));
        check("b2b_word2", 64'(rd_word), 64'(36'o777000000777));
        check("b2b_rddone_cnt", 64'(n_rdd - b_rdd), 64'(2));
        check("b2b_gap_ok", 64'(last_gap >= 1), 64'(1));
        check("b2b_no_err", 64'(n_err - b_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
